// File: rtl/alu_sweep_ctrl.sv
// Sweeps all eight ALU opcodes over latched operands and captures {carry, result} per opcode.
// Optional macro ALU_SWEEP_CHECKSUM_EN adds a checksum output (mod-256 sum of captured results).
module alu_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] a_in,
   input  logic [7:0] b_in,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_s,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   output logic       busy,
   output logic       done,
   input  logic [2:0] rd_addr,
   output logic [8:0] rd_data
`ifdef ALU_SWEEP_CHECKSUM_EN
   ,
   output logic [7:0] checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

   state_t     state_r;
   state_t     state_s;
   logic [3:0] settle_r;
   logic [8:0] slot_r [8];
   logic       accept_s;
   logic       capture_s;
   logic       last_s;

   assign accept_s  = (state_r == IDLE) && start;
   assign capture_s = (state_r == RUN) && (settle_r == SETTLE_LIM);
   assign last_s    = capture_s && (alu_s == 3'd7);
   assign rd_data   = slot_r[rd_addr];

   // Next-state decode for the sweep sequencer
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register with registered status flags derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy    <= (state_s == RUN);
         done    <= (state_s == DONE);
      end
   end

   // Operand latch, opcode stepping, settle counting and slot capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a    <= 8'd0;
         alu_b    <= 8'd0;
         alu_s    <= 3'd0;
         settle_r <= 4'd0;
         for (int i = 0; i < 8; i++) begin
            slot_r[i] <= 9'h000;
         end
      end else if (accept_s) begin
         alu_a    <= a_in;
         alu_b    <= b_in;
         alu_s    <= 3'd0;
         settle_r <= 4'd0;
      end else if (state_r == RUN) begin
         if (capture_s) begin
            slot_r[alu_s] <= {alu_carry, alu_result};
            alu_s         <= alu_s + 3'd1;
            settle_r      <= 4'd0;
         end else begin
            settle_r <= settle_r + 4'd1;
         end
      end
   end

`ifdef ALU_SWEEP_CHECKSUM_EN
   // Slot 7 is written on the same edge, so its value comes straight from the ALU
   function automatic logic [7:0] sweep_sum(input logic [8:0] slots [8], input logic [7:0] last);
      logic [7:0] acc;
      acc = last;
      for (int i = 0; i < 7; i++) begin
         acc = acc + slots[i][7:0];
      end
      return acc;
   endfunction

   // Checksum register, refreshed on the transition into DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= 8'd0;
      end else if (last_s) begin
         checksum <= sweep_sum(slot_r, alu_result);
      end
   end
`endif

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Self-checking bench for alu_sweep_ctrl: ALU stub result=a+b+s, carry=s[0].
// A scoreboard queue holds expected slot contents per accepted sweep.
module tb_alu_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [8:0] exp_q [$];
   logic [7:0] last_sum;

   // SETTLE_CYCLES=1 instance
   logic       start;
   logic [7:0] a_in, b_in, alu_a, alu_b, alu_result;
   logic [2:0] alu_s, rd_addr;
   logic       alu_carry, busy, done;
   logic [8:0] rd_data;
`ifdef ALU_SWEEP_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   // SETTLE_CYCLES=0 instance
   logic       z_start;
   logic [7:0] z_a, z_b, z_alu_a, z_alu_b, z_result;
   logic [2:0] z_alu_s, z_rd;
   logic       z_carry, z_busy, z_done;
   logic [8:0] z_rd_data;
`ifdef ALU_SWEEP_CHECKSUM_EN
   logic [7:0] z_checksum;
`endif

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign alu_result = alu_a + alu_b + {5'd0, alu_s};
   assign alu_carry  = alu_s[0];
   assign z_result   = z_alu_a + z_alu_b + {5'd0, z_alu_s};
   assign z_carry    = z_alu_s[0];

   alu_sweep_ctrl #(.SETTLE_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_result(alu_result),
      .alu_carry(alu_carry), .busy(busy), .done(done), .rd_addr(rd_addr),
      .rd_data(rd_data)
`ifdef ALU_SWEEP_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   alu_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .start(z_start), .a_in(z_a), .b_in(z_b),
      .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_s(z_alu_s), .alu_result(z_result),
      .alu_carry(z_carry), .busy(z_busy), .done(z_done), .rd_addr(z_rd),
      .rd_data(z_rd_data)
`ifdef ALU_SWEEP_CHECKSUM_EN
      , .checksum(z_checksum)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic push_sweep(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      for (int s = 0; s < 8; s++) begin
         r = a + b + 8'(s);
         exp_q.push_back({s[0], r});
      end
   endtask

   // Reads all 8 slots 1 time unit apart (fits inside the low clock phase)
   task automatic compare_slots(input bit which);
      logic [8:0] exp;
      logic [8:0] obs;
      last_sum = 8'd0;
      for (int i = 0; i < 8; i++) begin
         if (which) z_rd = 3'(i); else rd_addr = 3'(i);
         #1;
         obs = which ? z_rd_data : rd_data;
         if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            exp = exp_q.pop_front();
            last_sum = last_sum + exp[7:0];
            check_eq($sformatf("slot%0d", i), 32'(obs), 32'(exp));
         end
      end
`ifdef ALU_SWEEP_CHECKSUM_EN
      if (!which) check_eq("checksum", 32'(checksum), 32'(last_sum));
`endif
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_slots_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         check_eq($sformatf("%s_slot%0d", tag, i), 32'(rd_data), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, t1, t2, done_seen;
      rst_n = 1'b0; start = 1'b0; a_in = 8'd0; b_in = 8'd0; rd_addr = 3'd0;
      z_start = 1'b0; z_a = 8'd0; z_b = 8'd0; z_rd = 3'd0;
      repeat (2) @(negedge clk);

      // Reset state
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_alu_a", 32'(alu_a), 32'd0);
      check_eq("rst_alu_b", 32'(alu_b), 32'd0);
      check_eq("rst_alu_s", 32'(alu_s), 32'd0);
`ifdef ALU_SWEEP_CHECKSUM_EN
      check_eq("rst_checksum", 32'(checksum), 32'd0);
`endif
      check_slots_zero("rst");

      // Start on the first edge after release; late start at E0+5 must be ignored
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1; a_in = 8'd98; b_in = 8'd45;
      push_sweep(8'd98, 8'd45);
      @(negedge clk);
      e0 = cyc; start = 1'b0; a_in = 8'd7; b_in = 8'd9;
      check_eq("e0_busy", 32'(busy), 32'd1);
      check_eq("e0_alu_a", 32'(alu_a), 32'd98);
      check_eq("e0_alu_b", 32'(alu_b), 32'd45);
      check_eq("e0_alu_s", 32'(alu_s), 32'd0);
      repeat (4) @(negedge clk);
      start = 1'b1; a_in = 8'd255;
      @(negedge clk);
      start = 1'b0;
      check_eq("mid_alu_a", 32'(alu_a), 32'd98);
      check_eq("mid_alu_b", 32'(alu_b), 32'd45);
      check_eq("mid_alu_s", 32'(alu_s), 32'd2);
      check_eq("mid_busy", 32'(busy), 32'd1);
      wait_done(t1);
      check_eq("done_latency", 32'(t1 - e0), 32'd16);
      check_eq("done_busy", 32'(busy), 32'd0);
      compare_slots(1'b0);
      rd_addr = 3'd3;
      #1;
      check_eq("slot3_const", 32'(rd_data), 32'h192);
      @(negedge clk);
      check_eq("done_width", 32'(done), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);

      // Reset mid-sweep aborts without a done pulse
      start = 1'b1; a_in = 8'd98; b_in = 8'd45;
      @(negedge clk);
      e0 = cyc; start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_slots_zero("abort");
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check_eq("abort_no_done", 32'(done_seen), 32'd0);
      rst_n = 1'b1; start = 1'b1; a_in = 8'd200; b_in = 8'd100;
      push_sweep(8'd200, 8'd100);
      @(negedge clk);
      start = 1'b0;
      wait_done(t1);
      compare_slots(1'b0);
      rd_addr = 3'd0;
      #1;
      check_eq("wrap_slot0", 32'(rd_data), 32'd44);
      rd_addr = 3'd7;
      #1;
      check_eq("wrap_slot7", 32'(rd_data), 32'h133);

      // Start held high: back-to-back sweeps, 18-cycle done period
      @(negedge clk);
      start = 1'b1; a_in = 8'd10; b_in = 8'd20;
      push_sweep(8'd10, 8'd20);
      push_sweep(8'd10, 8'd20);
      wait_done(t1);
      compare_slots(1'b0);
      wait_done(t2);
      start = 1'b0;
      check_eq("done_period", 32'(t2 - t1), 32'd18);
      compare_slots(1'b0);

      // SETTLE_CYCLES=0: one opcode per cycle, done at E0+8
      @(negedge clk);
      z_start = 1'b1; z_a = 8'd1; z_b = 8'd2;
      push_sweep(8'd1, 8'd2);
      @(negedge clk);
      e0 = cyc; z_start = 1'b0;
      check_eq("z_alu_s0", 32'(z_alu_s), 32'd0);
      check_eq("z_busy", 32'(z_busy), 32'd1);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         check_eq($sformatf("z_alu_s%0d", k), 32'(z_alu_s), 32'(k));
      end
      @(negedge clk);
      check_eq("z_done_at_8", 32'(z_done), 32'd1);
      check_eq("z_done_busy", 32'(z_busy), 32'd0);
      check_eq("z_cycle", 32'(cyc - e0), 32'd8);
      compare_slots(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
